dsm_modulator: RTL and testbench

Parametrised single-bit delta-sigma modulator with selectable loop order (1 or 2), true quantiser feedback, saturating integrators, a one-entry input sample buffer with valid/ready handshake, and a sticky overload detector. It sits between the sample source (running at the input rate) and the 1-bit output path, and advances one modulator step per oversampling tick `i_en`. It supersedes the open-loop integrate-and-compare stage. It adds DAC feedback, second-order noise shaping, saturation and overload reporting.

---
 rtl/dsm_modulator.sv | 139 +++++++++++++
 tb/tb_dsm_modulator.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_modulator.sv
// Order-1/2 single-bit delta-sigma modulator with quantiser feedback, saturating integrators and sticky overload.
// o_data updates the cycle after an i_en tick; one-slot input buffer, o_ready low while a sample is pending.
module dsm_modulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ORDER      = 2,
  parameter int ACC_WIDTH  = DATA_WIDTH + 4,
  parameter int OVL_LIMIT  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_data,
  output logic                  o_tick,
  input  logic                  i_clr_overload,
  output logic                  o_overload
);

  localparam int SW = ACC_WIDTH + 2;
  localparam int CW = $clog2(OVL_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(OVL_LIMIT);

  localparam logic signed [SW-1:0] FS      = {{(SW-DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] ACC_MAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN = {3'b111, {(ACC_WIDTH-1){1'b0}}};

  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("dsm_modulator: ORDER must be 1 or 2");
  end
  if (ACC_WIDTH < DATA_WIDTH + 2) begin : g_bad_acc
    $error("dsm_modulator: ACC_WIDTH must be at least DATA_WIDTH+2");
  end
  if (OVL_LIMIT < 1) begin : g_bad_lim
    $error("dsm_modulator: OVL_LIMIT must be at least 1");
  end

  logic signed [DATA_WIDTH-1:0] smp_buf;
  logic signed [DATA_WIDTH-1:0] x_cur;
  logic                         pend;
  logic signed [ACC_WIDTH-1:0]  i1;
  logic signed [ACC_WIDTH-1:0]  i2;
  logic [CW-1:0]                ovl_cnt;

  logic signed [SW-1:0]         x_ext;
  logic signed [SW-1:0]         i1_ext;
  logic signed [SW-1:0]         i2_ext;
  logic signed [SW-1:0]         y;
  logic signed [SW-1:0]         sum1;
  logic signed [SW-1:0]         sum2;
  logic signed [ACC_WIDTH-1:0]  i1_nxt;
  logic signed [ACC_WIDTH-1:0]  i2_nxt;
  logic                         sat1;
  logic                         sat2;
  logic                         sat_tick;
  logic [CW-1:0]                cnt_inc;
  logic                         ovl_set;

  assign o_ready = ~pend;

  // Quantiser: sign of the last integrator, nothing else in the path.
  assign o_data = ~((ORDER == 1) ? i1[ACC_WIDTH-1] : i2[ACC_WIDTH-1]);

  always_comb begin
    x_ext  = {{(SW-DATA_WIDTH){x_cur[DATA_WIDTH-1]}}, x_cur};
    i1_ext = {{2{i1[ACC_WIDTH-1]}}, i1};
    i2_ext = {{2{i2[ACC_WIDTH-1]}}, i2};
    y      = o_data ? FS : -FS;
    sum1   = i1_ext + x_ext - y;
    sum2   = i2_ext + i1_ext - (y <<< 1);

    sat1   = 1'b0;
    i1_nxt = sum1[ACC_WIDTH-1:0];
    if (sum1 > ACC_MAX) begin
      sat1   = 1'b1;
      i1_nxt = ACC_MAX[ACC_WIDTH-1:0];
    end else if (sum1 < ACC_MIN) begin
      sat1   = 1'b1;
      i1_nxt = ACC_MIN[ACC_WIDTH-1:0];
    end

    sat2   = 1'b0;
    i2_nxt = sum2[ACC_WIDTH-1:0];
    if (sum2 > ACC_MAX) begin
      sat2   = 1'b1;
      i2_nxt = ACC_MAX[ACC_WIDTH-1:0];
    end else if (sum2 < ACC_MIN) begin
      sat2   = 1'b1;
      i2_nxt = ACC_MIN[ACC_WIDTH-1:0];
    end

    sat_tick = sat1 | ((ORDER == 2) & sat2);
    cnt_inc  = (ovl_cnt == LIM) ? LIM : ovl_cnt + CW'(1);
    ovl_set  = i_en & sat_tick & (cnt_inc == LIM);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      smp_buf    <= '0;
      x_cur      <= '0;
      pend       <= 1'b0;
      i1         <= '0;
      i2         <= '0;
      ovl_cnt    <= '0;
      o_overload <= 1'b0;
      o_tick     <= 1'b0;
    end else begin
      o_tick <= i_en;

      if (i_en) begin
        i1 <= i1_nxt;
        if (ORDER == 2) begin
          i2 <= i2_nxt;
        end
      end

      // A tick drains the slot; otherwise an empty slot may take a sample.
      if (i_en && pend) begin
        x_cur <= smp_buf;
        pend  <= 1'b0;
      end else if (i_valid && !pend) begin
        smp_buf <= i_data;
        pend    <= 1'b1;
      end

      if (ovl_set) begin
        ovl_cnt    <= LIM;
        o_overload <= 1'b1;
      end else if (i_clr_overload) begin
        ovl_cnt    <= '0;
        o_overload <= 1'b0;
      end else if (i_en) begin
        ovl_cnt <= sat_tick ? cnt_inc : '0;
      end
    end
  end

endmodule

// File: tb/tb_dsm_modulator.sv
// Bench for dsm_modulator: ORDER=1 and ORDER=2 instances share stimulus and are compared every cycle
// against an integer-arithmetic reference model, plus fixed expectations for the known waveforms.
module tb_dsm_modulator;

  localparam int     DW   = 16;
  localparam int     AW   = 20;
  localparam int     LIM  = 8;
  localparam longint FS   = 32768;
  localparam longint AMAX = 524287;
  localparam longint AMIN = -524288;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, valid, clr;
  logic [DW-1:0] data;
  logic          rdy1, dat1, tck1, ovl1;
  logic          rdy2, dat2, tck2, ovl2;
  logic [7:0]    obs;

  dsm_modulator #(.DATA_WIDTH(DW), .ORDER(1), .ACC_WIDTH(AW), .OVL_LIMIT(LIM)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid), .i_data(data),
    .o_ready(rdy1), .o_data(dat1), .o_tick(tck1),
    .i_clr_overload(clr), .o_overload(ovl1)
  );

  dsm_modulator #(.DATA_WIDTH(DW), .ORDER(2), .ACC_WIDTH(AW), .OVL_LIMIT(LIM)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid), .i_data(data),
    .o_ready(rdy2), .o_data(dat2), .o_tick(tck2),
    .i_clr_overload(clr), .o_overload(ovl2)
  );

  assign obs = {dat1, rdy1, tck1, ovl1, dat2, rdy2, tck2, ovl2};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: index 0 is the ORDER=1 loop, index 1 the ORDER=2 loop.
  longint m_i1[2];
  longint m_i2[2];
  longint m_x;
  longint m_q[$];
  int     m_cnt[2];
  bit     m_ovl[2];
  bit     m_tick[2];
  bit     m_sat[2];

  function automatic longint clamp(longint v);
    return (v > AMAX) ? AMAX : ((v < AMIN) ? AMIN : v);
  endfunction

  function automatic bit m_out(int k);
    return ((k == 0) ? m_i1[0] : m_i2[1]) >= 0;
  endfunction

  function automatic logic [7:0] m_vec();
    bit r;
    r = (m_q.size() == 0);
    return {m_out(0), r, m_tick[0], m_ovl[0], m_out(1), r, m_tick[1], m_ovl[1]};
  endfunction

  task automatic model_edge();
    bit     acc;
    bit     take;
    longint y, a, b;
    bit     s;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_i1[k] = 0; m_i2[k] = 0; m_cnt[k] = 0;
        m_ovl[k] = 0; m_tick[k] = 0; m_sat[k] = 0;
      end
      m_x = 0;
      m_q.delete();
    end else begin
      acc  = valid && (m_q.size() == 0);
      take = en && (m_q.size() != 0);
      for (int k = 0; k < 2; k++) begin
        s = 0;
        if (en) begin
          y = m_out(k) ? FS : -FS;
          a = m_i1[k] + m_x - y;
          b = m_i2[k] + m_i1[k] - 2 * y;
          s = (clamp(a) != a) || (k == 1 && clamp(b) != b);
          m_i1[k] = clamp(a);
          if (k == 1) m_i2[k] = clamp(b);
        end
        m_sat[k] = s;
        if (s && (m_cnt[k] + 1 >= LIM)) begin
          m_cnt[k] = LIM;
          m_ovl[k] = 1;
        end else if (clr) begin
          m_cnt[k] = 0;
          m_ovl[k] = 0;
        end else if (en) begin
          m_cnt[k] = s ? m_cnt[k] + 1 : 0;
        end
        m_tick[k] = en;
      end
      if (take) m_x = m_q.pop_front();
      if (acc) m_q.push_back(longint'($signed(data)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; valid = 0; clr = 0; data = '0;
    step();
    step();
    checks++;
    if (obs !== 8'b1100_1100) begin
      errors++;
      $display("FAIL reset_state obs=%b required=11001100", obs);
    end
    checks++;
    if (obs !== m_vec()) begin
      errors++;
      $display("FAIL reset_model cyc=%0d obs=%b required=%b", cyc, obs, m_vec());
    end
    rst = 0;
  endtask

  task automatic test_zero_toggle();
    en = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (dat1 !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL zero_toggle tick=%0d o_data=%b required=%b", i, dat1, (i % 2) == 1);
      end
      checks++;
      if (obs !== m_vec()) begin
        errors++;
        $display("FAIL zero_toggle_model cyc=%0d obs=%b required=%b", cyc, obs, m_vec());
      end
    end
    en = 0;
  endtask

  task automatic test_order1_pattern();
    logic [3:0] pat;
    int         ones;
    pat  = 4'b1101;
    ones = 0;
    en = 1;
    step();
    en = 0; valid = 1; data = 16'sd16384;
    step();
    checks++;
    if (rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL o1_accept_ready o_ready=%b required=0", rdy1);
    end
    valid = 0; en = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i < 8 && dat1) ones++;
      checks++;
      if (dat1 !== pat[i % 4]) begin
        errors++;
        $display("FAIL o1_pattern tick=%0d o_data=%b required=%b", i, dat1, pat[i % 4]);
      end
      checks++;
      if (obs !== m_vec()) begin
        errors++;
        $display("FAIL o1_pattern_model cyc=%0d obs=%b required=%b", cyc, obs, m_vec());
      end
    end
    checks++;
    if (ones != 6) begin
      errors++;
      $display("FAIL o1_ones8 count=%0d required=6", ones);
    end
    en = 0;
  endtask

  task automatic test_order2_density();
    int ones;
    ones = 0;
    rst = 1;
    step();
    rst = 0; valid = 1; data = 16'sd8192;
    step();
    valid = 0; en = 1;
    step();
    for (int i = 0; i < 4096; i++) begin
      step();
      if (dat2) ones++;
      checks++;
      if (obs !== m_vec()) begin
        errors++;
        $display("FAIL o2_density_model cyc=%0d obs=%b required=%b", cyc, obs, m_vec());
      end
    end
    checks++;
    if (ones < 2558 || ones > 2562) begin
      errors++;
      $display("FAIL o2_density ones=%0d required=2560+-2", ones);
    end
    checks++;
    if (ovl2 !== 1'b0) begin
      errors++;
      $display("FAIL o2_density_ovl o_overload=%b required=0", ovl2);
    end
    en = 0;
  endtask

  task automatic test_overload();
    int first_sat;
    int rise;
    first_sat = -1;
    rise      = -1;
    rst = 1;
    step();
    rst = 0; en = 1;
    step();
    step();
    en = 0; valid = 1; data = 16'h8000;
    step();
    valid = 0; en = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (first_sat < 0 && m_sat[1]) first_sat = i;
      if (rise < 0 && ovl2 === 1'b1) rise = i;
      checks++;
      if (obs !== m_vec()) begin
        errors++;
        $display("FAIL ovl_model cyc=%0d obs=%b required=%b", cyc, obs, m_vec());
      end
    end
    checks++;
    if (first_sat != 16) begin
      errors++;
      $display("FAIL ovl_first_sat tick=%0d required=16", first_sat);
    end
    checks++;
    if (first_sat < 0 || rise != first_sat + LIM - 1) begin
      errors++;
      $display("FAIL ovl_rise rise_tick=%0d required=%0d", rise, first_sat + LIM - 1);
    end
    clr = 1;
    step();
    clr = 0;
    checks++;
    if (ovl2 !== 1'b1) begin
      errors++;
      $display("FAIL ovl_clr_vs_set o_overload=%b required=1", ovl2);
    end
    en = 0; clr = 1;
    step();
    clr = 0;
    checks++;
    if (ovl2 !== 1'b0) begin
      errors++;
      $display("FAIL ovl_clr_idle o_overload=%b required=0", ovl2);
    end
    en = 1;
    for (int i = 0; i < LIM; i++) begin
      step();
      checks++;
      if (ovl2 !== (i == LIM - 1)) begin
        errors++;
        $display("FAIL ovl_reset_count tick=%0d o_overload=%b required=%b", i, ovl2, i == LIM - 1);
      end
    end
    en = 0;
  endtask

  task automatic test_reset_midstream();
    en = 0; valid = 1; data = 16'sd12345;
    step();
    checks++;
    if (rdy2 !== 1'b0) begin
      errors++;
      $display("FAIL mid_pend o_ready=%b required=0", rdy2);
    end
    valid = 0; rst = 1;
    step();
    rst = 0;
    checks++;
    if (obs !== 8'b1100_1100) begin
      errors++;
      $display("FAIL mid_reset obs=%b required=11001100", obs);
    end
    en = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (dat1 !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL mid_discard tick=%0d o_data=%b required=%b", i, dat1, (i % 2) == 1);
      end
      checks++;
      if (obs !== m_vec()) begin
        errors++;
        $display("FAIL mid_model cyc=%0d obs=%b required=%b", cyc, obs, m_vec());
      end
    end
    en = 0;
  endtask

  task automatic test_handshake();
    valid = 1;
    for (int i = 0; i < 64; i++) begin
      data = DW'($urandom);
      en   = ((i % 4) == 3);
      step();
      checks++;
      if (rdy1 !== ((i % 4) == 3)) begin
        errors++;
        $display("FAIL hs_ready cyc=%0d o_ready=%b required=%b", i, rdy1, (i % 4) == 3);
      end
      checks++;
      if (obs !== m_vec()) begin
        errors++;
        $display("FAIL hs_model cyc=%0d obs=%b required=%b", cyc, obs, m_vec());
      end
    end
    valid = 0; en = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      en    = $urandom_range(0, 1) != 0;
      valid = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 49) == 0);
      data  = ($urandom_range(0, 1) != 0) ? DW'($urandom) : DW'($urandom_range(0, 32767) - 16384);
      step();
      checks++;
      if (obs !== m_vec()) begin
        errors++;
        $display("FAIL rand_model cyc=%0d obs=%b required=%b", cyc, obs, m_vec());
      end
    end
    rst = 0; en = 0; valid = 0; clr = 0;
  endtask

  initial begin
    rst = 1; en = 0; valid = 0; clr = 0; data = '0;
    test_reset();
    test_zero_toggle();
    test_order1_pattern();
    test_order2_density();
    test_overload();
    test_reset_midstream();
    test_handshake();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
